// File: rtl/systolic_tile_seq.sv
// Command sequencer for one ROWS x COLS FP8 MAC tile: clear, skewed operand
// streaming, pipeline flush and a row-by-row result drain.
module systolic_tile_seq #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int K_W        = 8,
  parameter  int ACC_STAGES = 2,
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [K_W-1:0]  cmd_k,
  input  logic            cmd_mode_fp8,
  input  logic            cmd_bf16,
  output logic            mode_fp8,
  output logic            out_bf16_en,
  output logic            acc_clr,
  output logic            rd_en,
  output logic [K_W-1:0]  rd_k,
  output logic [ROWS-1:0] row_valid,
  output logic [COLS-1:0] col_valid,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RW-1:0]   res_row,
  output logic            busy,
  output logic            done,
  output logic            err_k0
);

  localparam int F   = ROWS + COLS + ACC_STAGES - 1;
  localparam int FW  = $clog2(F + 1);
  localparam int CW  = (K_W > FW) ? K_W : FW;
  localparam int SKW = (ROWS > COLS) ? ROWS : COLS;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [K_W-1:0]   r_k;
  logic             r_mode, r_bf16, r_err;
  logic [RW-1:0]    r_row;
  logic [SKW-1:0]   r_skew;
  logic             w_accept, w_k_zero, w_row_last;
  logic [CW-1:0]    w_k_last;

  assign cmd_ready  = (r_state == S_IDLE) & ~rst;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_k_zero   = (cmd_k == '0);
  assign w_k_last   = CW'(r_k) - CW'(1);
  assign w_row_last = (r_row == RW'(ROWS - 1));

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_k_zero)           w_next = S_CLEAR;
      S_CLEAR:                                       w_next = S_STREAM;
      S_STREAM: if (r_cnt == w_k_last)               w_next = S_FLUSH;
      S_FLUSH:  if (r_cnt == CW'(F - 1))             w_next = S_DRAIN;
      S_DRAIN:  if (res_ready && w_row_last)         w_next = S_DONE;
      S_DONE:                                        w_next = S_IDLE;
      default:                                       w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_bf16  <= 1'b0;
      r_err   <= 1'b0;
      r_row   <= '0;
      r_skew  <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept & w_k_zero;
      if (w_accept && !w_k_zero) begin
        r_k    <= cmd_k;
        r_mode <= cmd_mode_fp8;
        r_bf16 <= cmd_bf16;
      end
      // One counter serves both STREAM (operand index) and FLUSH (wait cycles).
      if (r_state != w_next)
        r_cnt <= '0;
      else if (r_state == S_STREAM || r_state == S_FLUSH)
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_DRAIN && res_ready)
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      // Wavefront skew: tap i is the read strobe delayed i+1 cycles.
      r_skew[0] <= (r_state == S_STREAM);
      for (int i = 1; i < SKW; i++)
        r_skew[i] <= r_skew[i-1];
    end
  end

  assign mode_fp8    = r_mode;
  assign out_bf16_en = r_bf16;
  assign err_k0      = r_err;
  assign acc_clr     = (r_state == S_CLEAR);
  assign rd_en       = (r_state == S_STREAM);
  assign rd_k        = r_cnt[K_W-1:0];
  assign row_valid   = r_skew[ROWS-1:0];
  assign col_valid   = r_skew[COLS-1:0];
  assign res_valid   = (r_state == S_DRAIN);
  assign res_row     = r_row;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule
